// File: rtl/mac_engine_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one dot-product engine among NUM_REQ controllers, one transaction in flight.
// Optional burst locking: define ARB_BURST_LOCK_EN to keep the grant on a requester until its req_last beat.
module mac_engine_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int PARALLEL_FACTOR = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int ACC_WIDTH       = 32
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_REQ-1:0]                            req_valid,
    input  logic [NUM_REQ-1:0]                            req_last,
    input  logic [NUM_REQ*PARALLEL_FACTOR*DATA_WIDTH-1:0] req_inputs,
    input  logic [NUM_REQ*PARALLEL_FACTOR*DATA_WIDTH-1:0] req_weights,
    output logic [NUM_REQ-1:0]                            req_ready,
    output logic [NUM_REQ-1:0]                            rsp_valid,
    output logic signed [ACC_WIDTH-1:0]                   rsp_sum,
    output logic                                          eng_i_valid,
    output logic [PARALLEL_FACTOR*DATA_WIDTH-1:0]         eng_inputs,
    output logic [PARALLEL_FACTOR*DATA_WIDTH-1:0]         eng_weights,
    input  logic                                          eng_o_valid,
    input  logic signed [ACC_WIDTH-1:0]                   eng_sum,
    output logic                                          busy,
    output logic                                          err_spurious
);

    localparam int VEC_W = PARALLEL_FACTOR * DATA_WIDTH;
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                       state_q, state_d;
    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic [PTR_W-1:0]             owner_q, owner_d;
    logic                         lock_q, lock_d;
    logic [VEC_W-1:0]             ins_q, ins_d;
    logic [VEC_W-1:0]             wts_q, wts_d;
    logic signed [ACC_WIDTH-1:0]  sum_q, sum_d;
    logic                         err_q, err_d;

    logic                         gnt_found;
    logic [PTR_W-1:0]             gnt_idx;
    logic [PTR_W-1:0]             gnt_nxt;

    // Search starts at ptr_q; a locked owner overrides the rotation.
    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(idx);
            end
        end
`ifdef ARB_BURST_LOCK_EN
        if (lock_q) begin
            gnt_found = req_valid[owner_q];
            gnt_idx   = owner_q;
        end
`endif
        gnt_nxt = PTR_W'((int'(gnt_idx) + 1) % NUM_REQ);
    end

`ifndef ARB_BURST_LOCK_EN
    logic unused_last;
    assign unused_last = ^req_last;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        lock_d      = lock_q;
        ins_d       = ins_q;
        wts_d       = wts_q;
        sum_d       = sum_q;
        err_d       = err_q | (eng_o_valid && (state_q != WAIT));
        req_ready   = '0;
        rsp_valid   = '0;
        eng_i_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // rst_n gating keeps req_ready low while reset is held.
                if (gnt_found && rst_n) begin
                    req_ready[gnt_idx] = 1'b1;
                    owner_d = gnt_idx;
                    ins_d   = req_inputs[int'(gnt_idx)*VEC_W +: VEC_W];
                    wts_d   = req_weights[int'(gnt_idx)*VEC_W +: VEC_W];
                    state_d = ISSUE;
`ifdef ARB_BURST_LOCK_EN
                    lock_d = !req_last[gnt_idx];
                    if (req_last[gnt_idx]) begin
                        ptr_d = gnt_nxt;
                    end
`else
                    ptr_d = gnt_nxt;
`endif
                end
            end
            ISSUE: begin
                eng_i_valid = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                if (eng_o_valid) begin
                    sum_d   = eng_sum;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            lock_q  <= 1'b0;
            ins_q   <= '0;
            wts_q   <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
            ins_q   <= ins_d;
            wts_q   <= wts_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
        end
    end

    assign eng_inputs   = ins_q;
    assign eng_weights  = wts_q;
    assign rsp_sum      = sum_q;
    assign err_spurious = err_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mac_engine_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mac_engine_arbiter with a 3-cycle-latency dot-product engine model.
module tb_mac_engine_arbiter;
    localparam int NR = 4;
    localparam int PF = 8;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int VW = PF * DW;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NR-1:0]        req_valid = '0;
    logic [NR-1:0]        req_last = '0;
    logic [NR*VW-1:0]     req_inputs = '0;
    logic [NR*VW-1:0]     req_weights = '0;
    logic [NR-1:0]        req_ready;
    logic [NR-1:0]        rsp_valid;
    logic signed [AW-1:0] rsp_sum;
    logic                 eng_i_valid;
    logic [VW-1:0]        eng_inputs;
    logic [VW-1:0]        eng_weights;
    logic                 eng_o_valid = 1'b0;
    logic signed [AW-1:0] eng_sum = '0;
    logic                 busy;
    logic                 err_spurious;

    mac_engine_arbiter #(
        .NUM_REQ(NR), .PARALLEL_FACTOR(PF), .DATA_WIDTH(DW), .ACC_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_last(req_last),
        .req_inputs(req_inputs), .req_weights(req_weights),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum),
        .eng_i_valid(eng_i_valid), .eng_inputs(eng_inputs), .eng_weights(eng_weights),
        .eng_o_valid(eng_o_valid), .eng_sum(eng_sum),
        .busy(busy), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic signed [AW-1:0] dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
        int s;
        s = 0;
        for (int k = 0; k < PF; k++)
            s += $signed(a[k*DW +: DW]) * $signed(b[k*DW +: DW]);
        return AW'(s);
    endfunction

    function automatic int oh2idx(input logic [NR-1:0] v);
        for (int k = 0; k < NR; k++)
            if (v[k]) return k;
        return -1;
    endfunction

    // Engine model: result strobe three cycles after the start pulse.
    int spur_req = 0;
    int spur_done = 0;
    initial begin : engine
        logic [2:0]           vpipe;
        logic signed [AW-1:0] spipe [3];
        vpipe = '0;
        for (int k = 0; k < 3; k++) spipe[k] = '0;
        forever begin
            @(posedge clk); #1;
            eng_o_valid = vpipe[2];
            eng_sum     = spipe[2];
            if (spur_req != spur_done) begin
                eng_o_valid = 1'b1;
                eng_sum     = 32'h0BAD;
                spur_done   = spur_req;
            end
            vpipe    = {vpipe[1:0], eng_i_valid};
            spipe[2] = spipe[1];
            spipe[1] = spipe[0];
            spipe[0] = dot(eng_inputs, eng_weights);
            if (!rst_n) vpipe = '0;
        end
    end

    int cyc = 0;
    initial forever begin @(posedge clk); cyc++; end

    int                   gnt_log[$];
    int                   gcyc_log[$];
    int                   rsp_own[$];
    logic signed [AW-1:0] rsp_val[$];
    initial forever begin
        @(negedge clk);
        if (|(req_valid & req_ready)) begin
            gnt_log.push_back(oh2idx(req_valid & req_ready));
            gcyc_log.push_back(cyc);
        end
        if (|rsp_valid) begin
            rsp_own.push_back(oh2idx(rsp_valid));
            rsp_val.push_back(rsp_sum);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_ops(input int r, input logic [DW-1:0] a, input logic [DW-1:0] w);
        for (int k = 0; k < PF; k++) begin
            req_inputs[(r*PF+k)*DW +: DW]  = a;
            req_weights[(r*PF+k)*DW +: DW] = w;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin tick(1); n++; end
        if (busy) chk("idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        int base, rb, n, n0, rc;
        logic acc0;
        int exp_ord [4];
        logic signed [AW-1:0] sum_before;

        // Reset state, including req_ready held low under reset
        tick(3);
        chk("rst_ctl", 64'({req_ready, rsp_valid, eng_i_valid, busy, err_spurious}), 64'(0));
        chk("rst_data", 64'(|{rsp_sum, eng_inputs, eng_weights}), 64'(0));
        req_valid = 4'hF; #1;
        chk("rst_ready_gated", 64'(req_ready), 64'(0));
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'(0));
        chk("post_rst_ctl", 64'({rsp_valid, eng_i_valid, err_spurious}), 64'(0));
        req_valid = 4'hF; #1;
        chk("first_gnt", 64'(req_ready), 64'(4'b0001));
        req_valid = '0;

        // Single request from req 2, latency trace
        set_ops(2, 8'd1, 8'd2);
        @(posedge clk); #1; req_valid = 4'b0100;
        @(negedge clk);
        chk("r2_ready", 64'(req_ready), 64'(4'b0100));
        chk("r2_eiv_T", 64'(eng_i_valid), 64'(0));
        @(posedge clk); #1; req_valid = '0;
        @(negedge clk);
        chk("r2_eiv", 64'(eng_i_valid), 64'(1));
        chk("r2_in", 64'(eng_inputs), {8{8'h01}});
        chk("r2_wt", 64'(eng_weights), {8{8'h02}});
        repeat (3) begin @(negedge clk); chk("r2_rsp_early", 64'(rsp_valid), 64'(0)); end
        @(negedge clk);
        chk("r2_rsp", 64'(rsp_valid), 64'(4'b0100));
        chk("r2_sum", 64'(rsp_sum), 64'(16));
        @(negedge clk);
        chk("r2_rsp_pulse", 64'(rsp_valid), 64'(0));
        chk("r2_idle", 64'(busy), 64'(0));
        chk("r2_sum_hold", 64'(rsp_sum), 64'(16));

        // Round robin, all four continuously valid
        tick(1);
        do_reset();
        for (int r = 0; r < NR; r++) set_ops(r, 8'(r + 1), 8'hFF);
        req_last  = 4'hF;
        base      = gnt_log.size();
        rb        = rsp_own.size();
        req_valid = 4'hF;
        n = 0;
        while (gnt_log.size() < base + 5 && n < 100) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1; req_valid = '0;
        wait_idle();
        if (gnt_log.size() < base + 5 || rsp_own.size() < rb + 5) begin
            chk("rr_count", 64'(gnt_log.size() - base), 64'(5));
        end else begin
            for (int i = 0; i < 5; i++) chk("rr_order", 64'(gnt_log[base+i]), 64'(i % 4));
            for (int i = 1; i < 5; i++) chk("rr_space", 64'(gcyc_log[base+i] - gcyc_log[base+i-1]), 64'(6));
            for (int i = 0; i < 5; i++) begin
                chk("rr_rsp_own", 64'(rsp_own[rb+i]), 64'(i % 4));
                chk("rr_rsp_sum", 64'(rsp_val[rb+i]), 64'(32'(-8 * ((i % 4) + 1))));
            end
        end

        // Burst: req 0 sends last=0,0,1 while req 1 stays valid
`ifdef ARB_BURST_LOCK_EN
        exp_ord = '{0, 0, 0, 1};
`else
        exp_ord = '{0, 1, 0, 1};
`endif
        do_reset();
        set_ops(0, 8'd1, 8'd1);
        set_ops(1, 8'd2, 8'd1);
        req_last  = 4'b0010;
        base      = gnt_log.size();
        req_valid = 4'b0011;
        n = 0; n0 = 0;
        while (gnt_log.size() < base + 4 && n < 200) begin
            @(negedge clk);
            acc0 = req_valid[0] & req_ready[0];
            @(posedge clk); #1;
            if (acc0) begin
                n0++;
                if (n0 == 2) req_last[0] = 1'b1;
                if (n0 == 3) req_valid[0] = 1'b0;
            end
            n++;
        end
        req_valid = '0;
        wait_idle();
        if (gnt_log.size() < base + 4) begin
            chk("burst_count", 64'(gnt_log.size() - base), 64'(4));
        end else begin
            for (int i = 0; i < 4; i++) chk("burst_order", 64'(gnt_log[base+i]), 64'(exp_ord[i]));
        end

        // Spurious engine strobe while idle
        tick(2);
        sum_before = rsp_sum;
        rc = rsp_own.size();
        spur_req++;
        tick(4);
        chk("spur_err", 64'(err_spurious), 64'(1));
        chk("spur_no_rsp", 64'(rsp_own.size()), 64'(rc));
        chk("spur_sum", 64'(rsp_sum), 64'(sum_before));
        chk("spur_busy", 64'(busy), 64'(0));
        tick(5);
        chk("spur_sticky", 64'(err_spurious), 64'(1));

        // Reset while waiting on the engine
        set_ops(1, 8'd3, 8'd3);
        req_valid = 4'b0010;
        tick(1);
        req_valid = '0;
        tick(1);
        chk("wait_busy", 64'(busy), 64'(1));
        rst_n = 1'b0; #1;
        chk("mid_rst_ctl", 64'({req_ready, rsp_valid, eng_i_valid, busy, err_spurious}), 64'(0));
        chk("mid_rst_data", 64'(|{rsp_sum, eng_inputs, eng_weights}), 64'(0));
        tick(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_mid_ctl", 64'({rsp_valid, eng_i_valid, busy, err_spurious}), 64'(0));
        req_valid = 4'hF; #1;
        chk("ptr_rst", 64'(req_ready), 64'(4'b0001));
        set_ops(3, 8'd5, 8'hFD);
        req_valid = 4'b1000; #1;
        chk("r3_ready", 64'(req_ready), 64'(4'b1000));
        rc = rsp_own.size();
        @(posedge clk); #1; req_valid = '0;
        tick(1);
        wait_idle();
        tick(1);
        if (rsp_own.size() <= rc) begin
            chk("r3_rsp_count", 64'(rsp_own.size() - rc), 64'(1));
        end else begin
            chk("r3_rsp_own", 64'(rsp_own[rc]), 64'(3));
            chk("r3_rsp_sum", 64'(rsp_val[rc]), 64'(32'(-120)));
        end
        chk("r3_no_err", 64'(err_spurious), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_engine_arbiter.md
MAC_ENGINE_ARBITER -- requirements
Module: mac_engine_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesting dense-layer controllers (2..8).
REQ-002 Parameter PARALLEL_FACTOR, default 8: operand lanes per transaction.
REQ-003 Parameter DATA_WIDTH, default 8: signed operand width.
REQ-004 Parameter ACC_WIDTH, default 32: signed sum-of-products width.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  NUM_REQ  per-requester transaction request.
REQ-008 req_last  in  NUM_REQ  marks final transaction of a requester's neuron burst.
REQ-009 req_inputs  in  NUM_REQ*PARALLEL_FACTOR*DATA_WIDTH  flat operand vectors, requester i at slice i.
REQ-010 req_weights  in  NUM_REQ*PARALLEL_FACTOR*DATA_WIDTH  flat weight vectors, same packing.
REQ-011 req_ready  out  NUM_REQ  one-hot accept; transfer when req_valid[i]&&req_ready[i].
REQ-012 rsp_valid  out  NUM_REQ  one-hot single-cycle result pulse to owning requester.
REQ-013 rsp_sum  out  ACC_WIDTH  signed result, held until next response.
REQ-014 eng_i_valid  out  1  start pulse to shared compute engine.
REQ-015 eng_inputs, eng_weights  out  PARALLEL_FACTOR*DATA_WIDTH each  latched operands of granted requester.
REQ-016 eng_o_valid  in  1  engine result strobe (any latency >=1).
REQ-017 eng_sum  in  ACC_WIDTH  engine result.
REQ-018 busy  out  1  high in any state except IDLE.
REQ-019 err_spurious  out  1  sticky flag: eng_o_valid seen outside WAIT.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, RESP; one transaction in flight at a time.
REQ-021 IDLE: grant computed combinationally, round-robin from pointer ptr; req_ready[g]=1 only for winner g, only in IDLE.
REQ-022 On accept at cycle T: latch owner=g, eng_inputs/eng_weights from slice g, latch req_last, ptr<=(g+1) mod NUM_REQ, go ISSUE.
REQ-023 ISSUE: eng_i_valid=1 for exactly one cycle (T+1), go WAIT; operands stable from T+1 until leaving RESP.
REQ-024 WAIT: on eng_o_valid capture rsp_sum<=eng_sum, go RESP; engine latency L gives rsp_valid[owner]=1 at T+2+L.
REQ-025 RESP: rsp_valid[owner] high one cycle, then IDLE; no response backpressure.
REQ-026 Minimum accept-to-accept spacing L+3 cycles; requesters hold req_valid and operands until accepted.
REQ-027 No requests in IDLE: all req_ready low, ptr unchanged.
REQ-028 eng_o_valid in IDLE/ISSUE/RESP: ignored for data, sets err_spurious; err_spurious cleared only by reset.
REQ-029 Pointer wraps NUM_REQ-1 -> 0; a requester dropping req_valid before accept forfeits nothing and stalls nobody (unless locked, REQ-033).

Reset
REQ-030 rst_n low at any time, including mid-WAIT: state IDLE, ptr=0, owner=0, lock cleared, all outputs 0 (req_ready, rsp_valid, rsp_sum, eng_i_valid, eng_inputs, eng_weights, busy, err_spurious).
REQ-031 Reset deassertion synchronised externally; first accept possible on first edge after release.

Configuration
REQ-032 Macro ARB_BURST_LOCK_EN selects burst locking.
REQ-033 Defined: accept with req_last=0 sets lock on owner; while locked only owner may be granted (others wait even if owner idle); accept with req_last=1 clears lock; ptr advances only on unlock.
REQ-034 Undefined: req_last ignored; re-arbitrate every transaction per REQ-021/022.

Verification (engine model latency L=3)
REQ-035 Reset: after rst_n release all outputs 0, busy=0, first grant with all valid goes to req 0.
REQ-036 req 2 only, inputs all 1, weights all 2, model returns 16: req_ready[2] at T, eng_i_valid T+1, rsp_valid[2] at T+5, rsp_sum=16.
REQ-037 All four valid continuously, req_last=1: grant order 0,1,2,3,0, spacing 6 cycles.
REQ-038 Lock defined: req 0 three transactions last=0,0,1, req 1 valid throughout: grants 0,0,0,1; undefined: 0,1,0,1.
REQ-039 eng_o_valid pulse in IDLE: err_spurious=1 and stays, no rsp_valid, rsp_sum unchanged.
REQ-040 rst_n low during WAIT: outputs 0 next cycle, ptr=0; later request from req 3 served normally.
